mux_sel_sequencer: RTL and testbench

MUX_SEL_SEQUENCER -- requirements
Module: mux_sel_sequencer

---
 rtl/mux_sel_sequencer.sv | 86 ++++++++
 tb/tb_mux_sel_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: scans a 4:1 mux through sel codes 0..3 and packs x_in into frame.
// Optional macro SEQ_AUTO_RESTART_EN: frame handshake restarts the scan without start.
module mux_sel_sequencer #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] x_in,
  input  logic       frame_ready,
  output logic [1:0] sel,
  output logic [7:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(DWELL - 1);

  state_t     state;
  logic [3:0] cnt;

  // Scan sequencer: dwell on each sel code, capture x_in, then hold frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= 2'd0;
      cnt         <= 4'd0;
      frame       <= 8'h00;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            sel   <= 2'd0;
            cnt   <= 4'd0;
          end
        end
        SCAN: begin
          if (cnt == LAST) begin
            cnt <= 4'd0;
            frame[{sel, 1'b0} +: 2] <= x_in;
            if (sel == 2'd3) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              sel         <= 2'd0;
            end else begin
              sel <= sel + 2'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
`ifdef SEQ_AUTO_RESTART_EN
            state <= SCAN;
            sel   <= 2'd0;
            cnt   <= 4'd0;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          sel         <= 2'd0;
          cnt         <= 4'd0;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: scoreboard bench with a 4:1 mux model on sel/x_in.
// Driver pushes expected frames; a negedge monitor pops and compares.
module tb_mux_sel_sequencer;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_ready = 1'b0;
  logic [1:0] sel;
  logic [1:0] x_in;
  logic [7:0] frame;
  logic       frame_valid;
  logic       busy;
  logic [1:0] inp [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] f;
    int         t0;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;
  logic prev_fv = 1'b0;

  mux_sel_sequencer #(.DWELL(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .x_in(x_in),
    .frame_ready(frame_ready),
    .sel(sel),
    .frame(frame),
    .frame_valid(frame_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign x_in = inp[sel];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int t0);
    exp_t e;
    e.f  = {inp[3], inp[2], inp[1], inp[0]};
    e.t0 = t0;
    q.push_back(e);
  endtask

  // Monitor: new frame pops the scoreboard; held frame must stay stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && frame_valid === 1'b1 && prev_fv !== 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: got %0h expected none", frame);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
          if (cur.t0 >= 0) chk("latency", cyc - cur.t0, 4 * D);
          chk("frame", frame, cur.f);
        end
      end else if (frame_valid === 1'b1 && have_cur) begin
        chk("frame_hold", frame, cur.f);
      end
      prev_fv = frame_valid;
    end
  end

  task automatic run_scan(input bit rnd, input bit glitch, input int bp);
    if (rnd) begin
      foreach (inp[i]) inp[i] = 2'($urandom);
    end else begin
      inp = '{2'd0, 2'd1, 2'd1, 2'd3};
    end
    push_exp(cyc + 1);
    start = 1'b1;
    frame_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4 * D; k++) begin
      chk("sel", sel, k / D);
      chk("busy_scan", busy, 1);
      chk("fv_scan", frame_valid, 0);
      start = glitch && (k == 2 * D);
      frame_ready = 1'($urandom);
      tick();
    end
    start = 1'b0;
    frame_ready = 1'b0;
    chk("fv_hold", frame_valid, 1);
    chk("busy_hold", busy, 1);
    chk("sel_hold", sel, 0);
    repeat (bp) begin
      tick();
      chk("fv_backpressure", frame_valid, 1);
    end
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("fv_after_hs", frame_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk("sel_after_hs", sel, 0);
    repeat (2) begin
      tick();
      chk("idle_stays", busy, 0);
    end
  endtask

  initial begin
    inp = '{2'd0, 2'd0, 2'd0, 2'd0};
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_sel", sel, 0);
    chk("rst_frame", frame, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
`ifdef SEQ_AUTO_RESTART_EN
    inp = '{2'd0, 2'd1, 2'd1, 2'd3};
    frame_ready = 1'b1;
    push_exp(cyc + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4 * D) tick();
    chk("auto_fv1", frame_valid, 1);
    inp = '{2'd3, 2'd3, 2'd3, 2'd3};
    push_exp(cyc + 1);
    tick();
    chk("auto_busy", busy, 1);
    chk("auto_fv_drop", frame_valid, 0);
    chk("auto_sel", sel, 0);
    repeat (4 * D) tick();
    chk("auto_fv2", frame_valid, 1);
    frame_ready = 1'b0;
    repeat (3) tick();
`else
    run_scan(0, 0, 0);
    run_scan(0, 0, 5);
    run_scan(0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * D) tick();
    chk("pre_abort_sel", sel, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_sel", sel, 0);
    chk("abort_frame", frame, 0);
    chk("abort_busy", busy, 0);
    chk("abort_fv", frame_valid, 0);
    repeat (2) begin
      tick();
      chk("abort_idle", busy, 0);
    end
    run_scan(0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      run_scan(1, ($urandom % 4) == 0, $urandom_range(0, 4));
    end
`endif
    repeat (2) tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
